instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Parametrised fetch stage that merges the program counter, memory read request and instruction register into one block. It drives a variable-latency instruction memory through a req/ready handshake and presents one instruction at a time to decode through a valid/stall handshake. It also supports branch redirect with flush. It sits between the instruction RAM and the decode/execute stage.

Parameters:
PC_WIDTH, 8, program counter width; PC wraps modulo 2^PC_WIDTH
ADDR_WIDTH, 16, memory address width; must be >= PC_WIDTH
DATA_WIDTH, 32, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per fetched word

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
stall  in  1  decode cannot accept; held instruction must not change
redirect  in  1  branch/jump taken this cycle
redirect_pc  in  PC_WIDTH  new fetch PC when redirect=1
mem_req  out  1  read request to instruction memory
mem_rw  out  1  constant 1 (read); 0 never driven
mem_address  out  ADDR_WIDTH  fetch PC, zero-extended
mem_ready  in  1  memory data valid this cycle; ignored unless mem_req=1
mem_data  in  DATA_WIDTH  instruction word from memory
instr_valid  out  1  instruction_out/pc_out hold a valid instruction
instruction_out  out  DATA_WIDTH  fetched instruction
pc_out  out  PC_WIDTH  PC of instruction_out

Behaviour:
- Reset (reset=0 at an edge):
  - fetch_pc=RESET_PC, state=IDLE, instr_valid=0, instruction_out=0, pc_out=RESET_PC.
  - mem_req=0 while reset is low.
  - Reset takes priority over every other input, including mid-wait.
- States:
  - IDLE: mem_req=0; next state FETCH unconditionally.
  - FETCH: mem_req = !instr_valid || !stall, i.e. the output slot is free or is being consumed this cycle.
- Handshake "accept": FETCH && mem_req && mem_ready. On accept at the edge:
  - instruction_out<=mem_data, pc_out<=fetch_pc, instr_valid<=1.
  - fetch_pc<=fetch_pc+PC_STEP, truncated to PC_WIDTH (wrap, e.g. 255+1 -> 0 at PC_WIDTH=8).
- Consume: instr_valid && !stall. If consumed with no accept in the same cycle, instr_valid<=0.
- Stall: while instr_valid && stall:
  - instruction_out and pc_out hold; mem_req=0; fetch_pc holds.
- Wait states: while mem_req=1 and mem_ready=0:
  - mem_address stays stable and mem_req stays high (unless stall deasserts it because the slot is full).
  - Any latency from 0 to N cycles must be supported.
- Zero-wait memory (mem_ready tied 1, stall=0): one instruction per cycle. The first instr_valid appears 2 cycles after reset release (IDLE, then FETCH accept).
- Redirect (priority below reset, above everything else):
  - fetch_pc<=redirect_pc, instr_valid<=0 (flush), state<=IDLE.
  - mem_data with mem_ready in the same cycle is discarded.
  - Any outstanding wait is abandoned. The IDLE cycle (mem_req=0) marks the abandon to memory; the new request starts the following cycle.
- Redirect during stall: flush wins; the held instruction is dropped.
- mem_address = {zeros, fetch_pc} combinationally; mem_rw=1 always.
- Outputs are not X after the first reset edge.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, FETCH}
  - constant RW_READ=1'b1
  - helper function next_pc(pc, step) with wrap truncation
- Sub-module fetch_pc_gen: holds fetch_pc, handles reset/redirect/increment priority; the top level owns the FSM and output register.

Test Plan:
- Reset held 3 cycles, then released, ready=1, stall=0, RAM word[i]=i+0x100 -> mem_req=0 during reset; instr_valid rises 2 cycles after release; pc_out 0,1,2,3 with instruction 0x100..0x103 on consecutive cycles.
- mem_ready asserted every 3rd cycle -> mem_address constant during each wait; each instruction appears exactly once; no skipped or duplicated PCs.
- stall=1 for 4 cycles while holding pc_out=5 -> instruction_out/pc_out unchanged, mem_req=0; after release, pc_out=6 follows within 1 cycle (ready=1).
- redirect=1, redirect_pc=0x40, during a wait with mem_ready=1 the same cycle -> that data discarded, instr_valid=0 next cycle, one IDLE cycle, then fetch at address 0x40; next pc_out=0x40.
- fetch_pc reaches 0xFF at PC_WIDTH=8 -> pc_out 0xFF then 0x00; mem_address 0x0000.
- reset driven low mid-wait and during a stall -> next edge: instr_valid=0, pc_out=RESET_PC, mem_req=0; clean restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  // Fetch controller states: IDLE marks a restart/abandon cycle, FETCH requests words.
  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  // Memory direction encoding; the fetch stage only ever reads.
  localparam logic RW_READ = 1'b1;

  // Advance a PC by step and wrap it to the given width (width <= 32).
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [31:0] step,
                                          input int unsigned width);
    logic [31:0] mask;
    if (width >= 32) mask = '1;
    else             mask = (32'd1 << width) - 32'd1;
    return (pc + step) & mask;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: reset beats redirect, redirect beats sequential advance.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                advance,
  output logic [PC_WIDTH-1:0] fetch_pc
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = PC_WIDTH'(next_pc(32'(fetch_pc), 32'(PC_STEP), PC_WIDTH));

  // Load the PC on reset or redirect, otherwise step it past each accepted word.
  always_ff @(posedge clk) begin
    if (!reset)        fetch_pc <= RESET_PC_V;
    else if (redirect) fetch_pc <= redirect_pc;
    else if (advance)  fetch_pc <= pc_inc;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, memory read request and a one-entry instruction register.
//
// Handshakes:
//   memory side : a word is taken on an edge where mem_req && mem_ready and no
//                 redirect is present; mem_address/mem_req stay put while waiting.
//   decode side : instr_valid offers instruction_out/pc_out; the word is consumed
//                 on an edge where instr_valid && !stall, and held while stall=1.
// ADDR_WIDTH must be at least PC_WIDTH; the address is the zero-extended PC.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC   = 0,
  parameter int PC_STEP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output fetch_state_e          dbg_state
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  fetch_state_e        state;
  fetch_state_e        state_next;
  logic                accept;
  logic                consume;
  logic [PC_WIDTH-1:0] fetch_pc;

  fetch_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (accept),
    .fetch_pc    (fetch_pc)
  );

  assign mem_address = ADDR_WIDTH'(fetch_pc);
  assign mem_rw      = RW_READ;
  assign dbg_state   = state;

  // State register; reset and redirect both restart through IDLE.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, memory request and handshake strobes.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   mem_req    = reset && (!instr_valid || !stall);
      default: state_next = IDLE;
    endcase
    if (redirect) state_next = IDLE;
    // A redirect in the same cycle discards whatever the memory returns.
    accept  = mem_req && mem_ready && !redirect;
    consume = instr_valid && !stall;
  end

  // Instruction register: flush on redirect, load on accept, drain on consume.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_valid     <= 1'b0;
      instruction_out <= '0;
      pc_out          <= RESET_PC_V;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr_valid     <= 1'b1;
      instruction_out <= mem_data;
      pc_out          <= fetch_pc;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked against a cycle-level behavioural model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        mem_req;
  logic        mem_rw;
  logic [15:0] mem_address;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instruction_out;
  logic [7:0]  pc_out;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .mem_req         (mem_req),
    .mem_rw          (mem_rw),
    .mem_address     (mem_address),
    .mem_ready       (mem_ready),
    .mem_data        (mem_data),
    .instr_valid     (instr_valid),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .dbg_state       (dbg_state)
  );

  // Instruction RAM contents: word[i] = i + 0x100.
  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'h100 + {16'h0, a};
  endfunction

  assign mem_data = ram_word(mem_address);

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_consumed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The slot holds at most one instruction; the fetch PC walks memory one word
  // per accepted read and restarts (after one idle cycle) on reset/redirect.
  bit         m_known    = 1'b0;
  bit         m_fetching = 1'b0;
  bit         m_valid    = 1'b0;
  logic [7:0] m_pc       = '0;
  logic [7:0] m_pcout    = '0;
  logic [31:0] m_instr   = '0;
  logic [39:0] exp_q[$];
  bit         have_last  = 1'b0;
  logic [7:0] last_pc    = '0;

  task automatic model_step();
    bit req;
    if (!reset) begin
      m_known = 1'b1; m_fetching = 1'b0; m_valid = 1'b0;
      m_pc = 8'h00; m_pcout = 8'h00; m_instr = '0;
      exp_q.delete(); have_last = 1'b0;
    end else if (m_known) begin
      if (redirect) begin
        m_pc = redirect_pc; m_fetching = 1'b0; m_valid = 1'b0;
        exp_q.delete(); have_last = 1'b0;
      end else begin
        req = m_fetching && (!m_valid || !stall);
        if (req && mem_ready) begin
          m_instr = ram_word({8'h00, m_pc});
          m_pcout = m_pc;
          m_valid = 1'b1;
          exp_q.push_back({m_pc, m_instr});
          m_pc = m_pc + 8'd1;
        end else if (m_valid && !stall) begin
          m_valid = 1'b0;
        end
        m_fetching = 1'b1;
      end
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process (mid-cycle) ----------------
  always begin
    logic [39:0] item;
    @(negedge clk);
    if (m_known) begin
      chk("mem_req", mem_req, reset && m_fetching && (!m_valid || !stall));
      chk("mem_address", mem_address, {8'h00, m_pc});
      chk("mem_rw", mem_rw, 1'b1);
      chk("instr_valid", instr_valid, m_valid);
      chk("dbg_state_fetch", dbg_state == FETCH, m_fetching);
      if (m_valid) begin
        chk("pc_out", pc_out, m_pcout);
        chk("instruction_out", instruction_out, m_instr);
      end
      // Scoreboard: every word handed to decode must be the oldest expected one,
      // and consumed PCs must be consecutive between flushes.
      if (reset && !redirect && instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          chk("consume_unexpected", {pc_out, instruction_out}, 40'h0);
        end else begin
          item = exp_q.pop_front();
          chk("consume_item", {pc_out, instruction_out}, item);
          if (have_last) chk("pc_sequence", item[39:32], 8'(last_pc + 8'd1));
          have_last = 1'b1;
          last_pc   = item[39:32];
          n_consumed++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1;

    // Reset held for 3 cycles, then zero-wait streaming.
    repeat (3) begin
      cyc(); #3;
      chk("req_in_reset", mem_req, 1'b0);
    end
    cyc(); reset = 1'b1; #3;
    chk("rel_valid0", instr_valid, 1'b0);
    chk("rel_req_idle", mem_req, 1'b0);
    chk("rel_pc_out", pc_out, 8'h00);
    chk("rel_instr", instruction_out, 32'h0);
    cyc(); #3;
    chk("rel1_valid", instr_valid, 1'b0);
    chk("rel1_req", mem_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #3;
      chk("stream_valid", instr_valid, 1'b1);
      chk("stream_pc", pc_out, 8'(i));
      chk("stream_instr", instruction_out, 32'h100 + 32'(i));
    end

    // Stall for 4 cycles while pc_out=5.
    cyc(); #3;
    chk("pre_stall_pc", pc_out, 8'h04);
    cyc(); stall = 1'b1; #3;
    chk("stall_pc", pc_out, 8'h05);
    chk("stall_req", mem_req, 1'b0);
    repeat (3) begin
      cyc(); #3;
      chk("stall_hold_pc", pc_out, 8'h05);
      chk("stall_hold_instr", instruction_out, 32'h105);
      chk("stall_hold_req", mem_req, 1'b0);
    end
    cyc(); stall = 1'b0; #3;
    chk("unstall_req", mem_req, 1'b1);
    cyc(); #3;
    chk("unstall_next_pc", pc_out, 8'h06);

    // Redirect during a memory wait, with ready present in the redirect cycle.
    mem_ready = 1'b0; #3;
    chk("wait_addr", mem_address, 16'h0007);
    cyc(); #3;
    chk("wait_valid0", instr_valid, 1'b0);
    chk("wait_addr1", mem_address, 16'h0007);
    cyc(); #3;
    chk("wait_addr2", mem_address, 16'h0007);
    cyc(); redirect = 1'b1; redirect_pc = 8'h40; mem_ready = 1'b1; #3;
    chk("redir_req", mem_req, 1'b1);
    cyc(); redirect = 1'b0; #3;
    chk("redir_valid0", instr_valid, 1'b0);
    chk("redir_idle_req", mem_req, 1'b0);
    chk("redir_idle_state", dbg_state == IDLE, 1'b1);
    chk("redir_addr", mem_address, 16'h0040);
    cyc(); #3;
    chk("redir_fetch_req", mem_req, 1'b1);
    chk("redir_fetch_valid0", instr_valid, 1'b0);
    cyc(); #3;
    chk("redir_pc_out", pc_out, 8'h40);
    chk("redir_instr", instruction_out, 32'h140);

    // PC wrap from 0xFF to 0x00.
    cyc(); redirect = 1'b1; redirect_pc = 8'hFE; #3;
    cyc(); redirect = 1'b0;
    cyc(); cyc(); #3;
    chk("wrap_pc_fe", pc_out, 8'hFE);
    cyc(); #3;
    chk("wrap_pc_ff", pc_out, 8'hFF);
    chk("wrap_addr0", mem_address, 16'h0000);
    cyc(); #3;
    chk("wrap_pc_00", pc_out, 8'h00);
    chk("wrap_instr", instruction_out, 32'h100);

    // Reset mid-wait.
    mem_ready = 1'b0;
    cyc(); cyc(); reset = 1'b0; #3;
    chk("rst_wait_req", mem_req, 1'b0);
    cyc(); reset = 1'b1; mem_ready = 1'b1; #3;
    chk("rst_wait_valid", instr_valid, 1'b0);
    chk("rst_wait_pc_out", pc_out, 8'h00);
    chk("rst_wait_addr", mem_address, 16'h0000);
    cyc(); cyc(); #3;
    chk("rst_wait_restart_pc", pc_out, 8'h00);
    chk("rst_wait_restart_v", instr_valid, 1'b1);

    // Reset during a stall.
    cyc(); stall = 1'b1;
    cyc(); reset = 1'b0; #3;
    chk("rst_stall_req", mem_req, 1'b0);
    cyc(); reset = 1'b1; stall = 1'b0; #3;
    chk("rst_stall_valid", instr_valid, 1'b0);
    chk("rst_stall_pc_out", pc_out, 8'h00);
    cyc(); cyc(); #3;
    chk("rst_stall_restart", pc_out, 8'h00);
    chk("rst_stall_instr", instruction_out, 32'h100);

    // Memory ready on every third cycle.
    for (int k = 0; k < 300; k++) begin
      cyc();
      mem_ready = (k % 3 == 2);
    end

    // Fully randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      cyc();
      mem_ready   = ($urandom_range(0, 2) != 0);
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = 8'($urandom_range(0, 255));
      reset       = ($urandom_range(0, 199) != 0);
    end
    cyc(); reset = 1'b1; redirect = 1'b0; stall = 1'b0; mem_ready = 1'b1;
    repeat (5) cyc();
    chk("consumed_enough", n_consumed > 200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
